dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port 32x32 data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/DMA loader). Each requester has a valid/ready request channel and a one-cycle response pulse. Arbitration is fixed priority to port 0, with a starvation limit that forces a port-1 grant. Sits between the requesters and the data memory; it drives the memory's address, write-data, read-strobe and write-strobe inputs and samples its combinational read data.

Parameters:
ADDR_W, 5, memory word-address width (32 words)
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 waits; legal range 1..15

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous reset, active-low
req0_valid  in  1  port-0 request present
req0_ready  out  1  port-0 request accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  word address
req0_wdata  in  DATA_W  write data
rsp0_valid  out  1  one-cycle completion pulse for port 0
rsp0_rdata  out  DATA_W  read data, valid with rsp0_valid
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1
mem_addr  out  ADDR_W  to memory DataAddr
mem_wdata  out  DATA_W  to memory DataIn
mem_r  out  1  to memory DMemR
mem_w  out  1  to memory DMemW
mem_rdata  in  DATA_W  from memory DataOut (combinational read)

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; starve counter = 0; all outputs 0, including ready, rsp_valid, rsp_rdata, mem_* outputs.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each transaction is exactly 3 cycles, so peak throughput is 1 access per 3 cycles.
- IDLE, grant selection:
  - Only one valid request: grant it.
  - Both valid: grant port 1 if starve_cnt == STARVE_LIMIT, otherwise grant port 0.
  - reqN_ready is combinational and high only in IDLE, only for the granted port. At most one ready is high per cycle.
  - On handshake (valid & ready): latch we, addr, wdata and the owner index; go to ACCESS.
- ACCESS: mem_addr = latched addr. mem_w = we, mem_r = !we, mutually exclusive. mem_wdata = latched wdata when writing, else 0. On a read, mem_rdata is captured into the response register at the end of this cycle. Go to RESP.
- RESP: rsp_valid = 1 for the owner only, for exactly one cycle. rsp_rdata = captured data for reads, 0 for writes. The non-owner's rsp_rdata is 0. Go to IDLE.
- Outside ACCESS: mem_r = mem_w = 0; mem_addr = 0; mem_wdata = 0.
- Starve counter (updated only on an IDLE handshake), 4-bit:
  - Port-0 grant with req1_valid high: increment, saturating at STARVE_LIMIT.
  - Port-1 grant: clear.
  - Port-0 grant with req1_valid low: clear.
- Handshake rules:
  - A requester may hold valid through ACCESS/RESP. It is not accepted until the next IDLE.
  - Request fields must be stable while valid and not ready. Dropping valid before ready is legal; nothing is recorded.
- Read-after-write: a write in transaction N is visible to a read in transaction N+1, because the memory commits on the ACCESS posedge.
- Address wrap: none. Addresses are full ADDR_W; all 32 words are addressable.
- Reset mid-operation:
  - Asserting rst in ACCESS drops mem_w immediately; a write not yet clocked is lost.
  - No response is emitted for the aborted transaction.
  - After rst deasserts: IDLE, starve counter 0.
- Memory contents are not cleared by this block.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - port index constants PORT_CPU = 0, PORT_DBG = 1
  - STARVE_CNT_W = 4
- One sub-module, dmem_arb_pick: purely combinational grant logic. Inputs: req0_valid, req1_valid, starve_cnt, STARVE_LIMIT. Outputs: gnt0, gnt1, any_gnt.
- FSM, latches and counter live in dmem_arbiter.

Test Plan:
1. Port-0 write addr 3 = 0xDEADBEEF, then port-0 read addr 3:
   - req0_ready high in the IDLE cycle; mem_w = 1 one cycle later.
   - rsp0_valid for 1 cycle each transaction; the read returns rsp0_rdata = 0xDEADBEEF.
2. Port 0 and port 1 both raise valid in the same IDLE cycle (reads of addr 1 and addr 2):
   - Port 0 served first (mem_addr = 1); port 1 follows in the next transaction (mem_addr = 2).
   - rsp1_valid is 3 cycles after rsp0_valid.
3. Starvation, STARVE_LIMIT = 4, both valid continuously:
   - Grant order: 0, 0, 0, 0, 1, 0, 0, 0, 0, 1.
   - rsp1_valid is never more than 15 cycles apart after the first.
4. Port-1 write addr 31 = 0x12345678, then port-0 read addr 31:
   - Returns 0x12345678; rsp1_rdata = 0 on the write response.
5. rst low during ACCESS of a port-0 write of 0xAAAA5555 to addr 7 (prior value 0):
   - mem_w falls immediately; no rsp0_valid.
   - A later port-0 read of addr 7 returns 0; starve counter reads 0.
6. req1_valid pulsed for one cycle during port-0 ACCESS, then dropped:
   - No port-1 grant occurs; port 0 continues unaffected; starve counter stays 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection: port 0 wins ties unless port 1 has waited
// through STARVE_LIMIT consecutive port-0 grants.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    req0_valid,
    input  logic                    req1_valid,
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    any_gnt
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic forceDbg;

    // Port 1 wins when alone or when the starve counter has hit the limit.
    always_comb begin
        forceDbg = (starve_cnt == LIMIT);
        gnt1     = req1_valid & (~req0_valid | forceDbg);
        gnt0     = req0_valid & ~gnt1;
        any_gnt  = gnt0 | gnt1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the
// debug/DMA loader (port 1). Every transaction is IDLE -> ACCESS -> RESP.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_r,
    output logic              mem_w,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    state_t                  state, nextState;
    logic                    owner;
    logic                    latWe;
    logic [ADDR_W-1:0]       latAddr;
    logic [DATA_W-1:0]       latWdata;
    logic [DATA_W-1:0]       rspData;
    logic [STARVE_CNT_W-1:0] starveCnt;
    logic                    gnt0, gnt1, anyGnt;
    logic                    handshake;

    dmem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) uPick (
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .starve_cnt (starveCnt),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .any_gnt    (anyGnt)
    );

    // Ready is only ever raised for the granted port, so any grant in IDLE is a handshake.
    assign handshake = (state == IDLE) & anyGnt;

    // State register; async reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next state and all outputs, decoded from the current state.
    always_comb begin
        nextState  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (anyGnt) nextState = ACCESS;
            end
            ACCESS: begin
                mem_addr  = latAddr;
                mem_w     = latWe;
                mem_r     = ~latWe;
                mem_wdata = latWe ? latWdata : '0;
                nextState = RESP;
            end
            RESP: begin
                if (owner == PORT_CPU) begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = rspData;
                end else begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = rspData;
                end
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Capture the winning request on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= PORT_CPU;
            latWe    <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
        end else if (handshake) begin
            owner    <= gnt1 ? PORT_DBG : PORT_CPU;
            latWe    <= gnt1 ? req1_we    : req0_we;
            latAddr  <= gnt1 ? req1_addr  : req0_addr;
            latWdata <= gnt1 ? req1_wdata : req0_wdata;
        end
    end

    // Sample the combinational memory read at the end of ACCESS; writes respond with zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 rspData <= '0;
        else if (state == ACCESS) rspData <= latWe ? '0 : mem_rdata;
    end

    // Count port-0 wins over a waiting port 1; any other grant resets the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= '0;
        end else if (handshake) begin
            if (gnt0 && req1_valid)
                starveCnt <= (starveCnt == LIMIT) ? starveCnt : starveCnt + 1'b1;
            else
                starveCnt <= '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32x32 memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we;
    logic [4:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [4:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_r, mem_w;
    logic [31:0] mem_rdata;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    logic [31:0] mem [32] = '{default: 32'h0};
    logic        bdWe = 1'b0;
    logic [4:0]  bdAddr = '0;
    logic [31:0] bdData = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, commits on posedge while DMemW is high.
    always @(posedge clk) begin
        if (mem_w)     mem[mem_addr] <= mem_wdata;
        else if (bdWe) mem[bdAddr]   <= bdData;
    end
    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_r(mem_r), .mem_w(mem_w),
        .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        #1;
        nChecks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_r, mem_w} !== 6'b0 ||
            rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0 || mem_addr !== 5'h0 || mem_wdata !== 32'h0) begin
            nFails++;
            $display("FAIL reset_outputs: got rdy=%b%b rsp=%b%b mem_rw=%b%b addr=%h want all zero",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_r, mem_w, mem_addr);
        end
        tick; tick;
        rst = 1'b1;
        tick;
        nChecks++;
        if (dut.state !== IDLE || dut.starveCnt !== 4'd0) begin
            nFails++;
            $display("FAIL reset_state: got state=%0d cnt=%0d want 0/0", dut.state, dut.starveCnt);
        end
    endtask

    task automatic test_write_read;
        drive0(1, 1, 5'd3, 32'hDEADBEEF);
        #1;
        nChecks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            nFails++; $display("FAIL wr_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        tick;
        drive0(0, 0, 0, 0);
        nChecks++;
        if (mem_w !== 1'b1 || mem_r !== 1'b0 || mem_addr !== 5'd3 || mem_wdata !== 32'hDEADBEEF) begin
            nFails++; $display("FAIL wr_access: got w=%b r=%b a=%0d d=%h want 1 0 3 deadbeef", mem_w, mem_r, mem_addr, mem_wdata);
        end
        tick;
        nChecks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0 || mem_w !== 1'b0) begin
            nFails++; $display("FAIL wr_resp: got v=%b d=%h mem_w=%b want 1 0 0", rsp0_valid, rsp0_rdata, mem_w);
        end
        tick;
        nChecks++;
        if (rsp0_valid !== 1'b0) begin
            nFails++; $display("FAIL wr_resp_pulse: got %b want 0", rsp0_valid);
        end
        drive0(1, 0, 5'd3, 32'h0);
        #1;
        tick;
        drive0(0, 0, 0, 0);
        nChecks++;
        if (mem_r !== 1'b1 || mem_w !== 1'b0 || mem_wdata !== 32'h0) begin
            nFails++; $display("FAIL rd_access: got r=%b w=%b d=%h want 1 0 0", mem_r, mem_w, mem_wdata);
        end
        tick;
        nChecks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEEF) begin
            nFails++; $display("FAIL rd_resp: got v=%b d=%h want 1 deadbeef", rsp0_valid, rsp0_rdata);
        end
        tick;
    endtask

    task automatic test_contention;
        int c0;
        bdWe = 1; bdAddr = 5'd1; bdData = 32'h1111_0001; tick;
        bdAddr = 5'd2; bdData = 32'h2222_0002; tick;
        bdWe = 0;
        drive0(1, 0, 5'd1, 0);
        drive1(1, 0, 5'd2, 0);
        #1;
        nChecks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            nFails++; $display("FAIL both_first_grant: got rdy=%b%b want 10", req0_ready, req1_ready);
        end
        tick;
        req0_valid = 0;
        nChecks++;
        if (mem_addr !== 5'd1 || req1_ready !== 1'b0) begin
            nFails++; $display("FAIL both_access0: got addr=%0d rdy1=%b want 1 0", mem_addr, req1_ready);
        end
        tick;
        c0 = cyc;
        nChecks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h1111_0001 || rsp1_valid !== 1'b0) begin
            nFails++; $display("FAIL both_rsp0: got v=%b d=%h v1=%b want 1 11110001 0", rsp0_valid, rsp0_rdata, rsp1_valid);
        end
        tick;
        nChecks++;
        if (req1_ready !== 1'b1) begin
            nFails++; $display("FAIL both_second_grant: got rdy1=%b want 1", req1_ready);
        end
        tick;
        req1_valid = 0;
        nChecks++;
        if (mem_addr !== 5'd2) begin
            nFails++; $display("FAIL both_access1: got addr=%0d want 2", mem_addr);
        end
        tick;
        nChecks++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h2222_0002 || rsp0_rdata !== 32'h0 || cyc - c0 != 3) begin
            nFails++; $display("FAIL both_rsp1: got v=%b d=%h r0=%h gap=%0d want 1 22220002 0 3",
                               rsp1_valid, rsp1_rdata, rsp0_rdata, cyc - c0);
        end
        tick;
    endtask

    task automatic test_starvation;
        logic [9:0] expDbg;
        int lastRsp1;
        expDbg = 10'b10_0001_0000;
        lastRsp1 = -1;
        drive0(1, 0, 5'd0, 0);
        drive1(1, 0, 5'd0, 0);
        #1;
        for (int t = 0; t < 10; t++) begin
            nChecks++;
            if (req1_ready !== expDbg[t] || req0_ready !== ~expDbg[t]) begin
                nFails++; $display("FAIL starve_grant_%0d: got rdy=%b%b want dbg=%b", t, req0_ready, req1_ready, expDbg[t]);
            end
            tick; tick;
            if (rsp1_valid === 1'b1) begin
                if (lastRsp1 >= 0) begin
                    nChecks++;
                    if (cyc - lastRsp1 != 15) begin
                        nFails++; $display("FAIL starve_gap: got %0d cycles want 15", cyc - lastRsp1);
                    end
                end
                lastRsp1 = cyc;
            end
            tick;
        end
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        nChecks++;
        if (dut.starveCnt !== 4'd0) begin
            nFails++; $display("FAIL starve_cnt_after: got %0d want 0", dut.starveCnt);
        end
    endtask

    task automatic test_dbg_write;
        drive1(1, 1, 5'd31, 32'h12345678);
        #1;
        nChecks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            nFails++; $display("FAIL dbgwr_ready: got rdy=%b%b want 01", req0_ready, req1_ready);
        end
        tick;
        drive1(0, 0, 0, 0);
        nChecks++;
        if (mem_w !== 1'b1 || mem_addr !== 5'd31 || mem_wdata !== 32'h12345678) begin
            nFails++; $display("FAIL dbgwr_access: got w=%b a=%0d d=%h want 1 31 12345678", mem_w, mem_addr, mem_wdata);
        end
        tick;
        nChecks++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h0 || rsp0_valid !== 1'b0) begin
            nFails++; $display("FAIL dbgwr_resp: got v1=%b d1=%h v0=%b want 1 0 0", rsp1_valid, rsp1_rdata, rsp0_valid);
        end
        tick;
        drive0(1, 0, 5'd31, 0);
        #1;
        tick;
        drive0(0, 0, 0, 0);
        tick;
        nChecks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h12345678) begin
            nFails++; $display("FAIL raw_addr31: got v=%b d=%h want 1 12345678", rsp0_valid, rsp0_rdata);
        end
        tick;
    endtask

    task automatic test_reset_mid_access;
        drive0(1, 1, 5'd7, 32'hAAAA5555);
        drive1(1, 0, 5'd9, 0);
        #1;
        tick;
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        nChecks++;
        if (mem_w !== 1'b1 || dut.starveCnt !== 4'd1) begin
            nFails++; $display("FAIL abort_pre: got mem_w=%b cnt=%0d want 1 1", mem_w, dut.starveCnt);
        end
        rst = 1'b0;
        #1;
        nChecks++;
        if (mem_w !== 1'b0 || mem_addr !== 5'd0 || mem_wdata !== 32'h0) begin
            nFails++; $display("FAIL abort_mem_w: got w=%b a=%0d d=%h want 0 0 0", mem_w, mem_addr, mem_wdata);
        end
        tick;
        rst = 1'b1;
        nChecks++;
        if (rsp0_valid !== 1'b0 || dut.starveCnt !== 4'd0 || dut.state !== IDLE) begin
            nFails++; $display("FAIL abort_state: got v=%b cnt=%0d st=%0d want 0 0 0", rsp0_valid, dut.starveCnt, dut.state);
        end
        tick;
        nChecks++;
        if (rsp0_valid !== 1'b0) begin
            nFails++; $display("FAIL abort_no_rsp: got %b want 0", rsp0_valid);
        end
        drive0(1, 0, 5'd7, 0);
        #1;
        tick;
        drive0(0, 0, 0, 0);
        tick;
        nChecks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0) begin
            nFails++; $display("FAIL abort_lost_write: got v=%b d=%h want 1 0", rsp0_valid, rsp0_rdata);
        end
        tick;
    endtask

    task automatic test_dbg_pulse;
        logic sawRdy1, sawRsp1;
        sawRdy1 = 0; sawRsp1 = 0;
        drive0(1, 0, 5'd3, 0);
        #1;
        tick;
        drive0(0, 0, 0, 0);
        drive1(1, 0, 5'd5, 0);
        #1;
        sawRdy1 = sawRdy1 | req1_ready;
        tick;
        drive1(0, 0, 0, 0);
        #1;
        nChecks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEEF) begin
            nFails++; $display("FAIL pulse_rsp0: got v=%b d=%h want 1 deadbeef", rsp0_valid, rsp0_rdata);
        end
        for (int i = 0; i < 5; i++) begin
            sawRdy1 = sawRdy1 | req1_ready;
            sawRsp1 = sawRsp1 | rsp1_valid | mem_r;
            tick;
        end
        nChecks++;
        if (sawRdy1 !== 1'b0 || sawRsp1 !== 1'b0 || dut.starveCnt !== 4'd0) begin
            nFails++; $display("FAIL pulse_no_grant: got rdy1=%b act=%b cnt=%0d want 0 0 0", sawRdy1, sawRsp1, dut.starveCnt);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_contention;
        test_starvation;
        test_dbg_write;
        test_reset_mid_access;
        test_dbg_pulse;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
